// File: rtl/spi_endpoint_router.sv
// -----------------------------------------------------------------------------
// spi_endpoint_router
//
// Routes the SPI stack's request stream to one of num_ends endpoints and
// merges the endpoint responses back into a single stream for the stack.
//
// Request path : a one-entry pipe buffer captures {dest, payload}. The payload
//                is broadcast to every endpoint, and ep_req_val is one-hot on
//                the buffered destination. A stalled target stalls all
//                requests (head-of-line blocking, no reordering).
// Response path: a round-robin arbiter picks one valid endpoint per cycle
//                into a one-entry buffer. The response is tagged with the
//                source id in the top addr_nbits bits.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   recv_val     upstream request valid
//   recv_msg     upstream request {dest, payload}
//   recv_rdy     upstream request ready (combinational)
//   send_val     upstream response valid (registered)
//   send_msg     upstream response {src_id, payload} (registered)
//   send_rdy     upstream response ready
//   ep_req_val   per-endpoint request valid, one-hot or zero (registered)
//   ep_req_msg   request payload broadcast to all endpoints (registered)
//   ep_req_rdy   per-endpoint request ready
//   ep_resp_val  per-endpoint response valid
//   ep_resp_msg  packed endpoint responses, endpoint i at [i*P +: P]
//   ep_resp_rdy  per-endpoint response ready, one-hot or zero (combinational)
//
// num_ends must equal 2**addr_nbits: the id arithmetic wraps on its own width.
// -----------------------------------------------------------------------------
module spi_endpoint_router #(
   parameter int nbits      = 32,
   parameter int addr_nbits = 2,
   parameter int num_ends   = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    recv_val,
   input  logic [nbits-1:0]                        recv_msg,
   output logic                                    recv_rdy,
   output logic                                    send_val,
   output logic [nbits-1:0]                        send_msg,
   input  logic                                    send_rdy,
   output logic [num_ends-1:0]                     ep_req_val,
   output logic [nbits-addr_nbits-1:0]             ep_req_msg,
   input  logic [num_ends-1:0]                     ep_req_rdy,
   input  logic [num_ends-1:0]                     ep_resp_val,
   input  logic [num_ends*(nbits-addr_nbits)-1:0]  ep_resp_msg,
   output logic [num_ends-1:0]                     ep_resp_rdy
);

   localparam int P = nbits - addr_nbits;

   // ---------------------------------------------------------------------------
   // Request path
   // ---------------------------------------------------------------------------
   logic                  req_full;
   logic [addr_nbits-1:0] dest_buf;
   logic [P-1:0]          payload_buf;
   logic                  req_drain;
   logic                  req_fire;

   assign req_drain = req_full && ep_req_rdy[dest_buf];

   // The buffer can refill in the same cycle its current entry drains.
   // Reset masks ready, so no handshake completes during reset.
   assign recv_rdy  = !reset && (!req_full || ep_req_rdy[dest_buf]);
   assign req_fire  = recv_val && recv_rdy;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of the order of the blocks.
      if (reset) begin
         req_full <= 1'b0;
      end else if (req_fire) begin
         req_full <= 1'b1;
      end else if (req_drain) begin
         req_full <= 1'b0;
      end
   end

   // NOTE: data registers are not reset. The full flag qualifies them, so
   // their content after reset is never observed as valid.
   always_ff @(posedge clk) begin
      if (req_fire) begin
         dest_buf    <= recv_msg[nbits-1 -: addr_nbits];
         payload_buf <= recv_msg[P-1:0];
      end
   end

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so
      // no path leaves it unassigned and no latch is inferred.
      ep_req_val = '0;
      for (int i = 0; i < num_ends; i++) begin
         ep_req_val[i] = req_full && (dest_buf == addr_nbits'(i));
      end
   end

   assign ep_req_msg = payload_buf;

   // ---------------------------------------------------------------------------
   // Response path
   // ---------------------------------------------------------------------------
   logic                  resp_full;
   logic [nbits-1:0]      resp_buf;
   logic [addr_nbits-1:0] rr_ptr;
   logic [addr_nbits-1:0] grant;
   logic [P-1:0]          grant_msg;
   logic                  any_val;
   logic                  arb_en;
   logic                  resp_fire;

   assign any_val   = |ep_resp_val;
   assign arb_en    = !resp_full || send_rdy;
   assign resp_fire = !reset && arb_en && any_val;

   // Round-robin search starting at rr_ptr. The index is addr_nbits wide, so
   // rr_ptr + k wraps modulo num_ends without an explicit modulo.
   always_comb begin
      logic [addr_nbits-1:0] idx;
      logic                  found;
      grant = '0;
      idx   = '0;
      found = 1'b0;
      for (int k = 0; k < num_ends; k++) begin
         idx = rr_ptr + addr_nbits'(k);
         if (!found && ep_resp_val[idx]) begin
            grant = idx;
            found = 1'b1;
         end
      end
   end

   assign grant_msg = ep_resp_msg[int'(grant)*P +: P];

   always_comb begin
      ep_resp_rdy = '0;
      for (int i = 0; i < num_ends; i++) begin
         ep_resp_rdy[i] = resp_fire && (grant == addr_nbits'(i));
      end
   end

   // The pointer moves only on a completed grant. It lands one past the
   // winner, so the winner has the lowest priority next time.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_full <= 1'b0;
         rr_ptr    <= '0;
      end else if (resp_fire) begin
         resp_full <= 1'b1;
         rr_ptr    <= grant + addr_nbits'(1);
      end else if (send_rdy) begin
         resp_full <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (resp_fire) begin
         resp_buf <= {grant, grant_msg};
      end
   end

   assign send_val = resp_full;
   assign send_msg = resp_buf;

endmodule

// File: tb/tb_spi_endpoint_router.sv
// -----------------------------------------------------------------------------
// tb_spi_endpoint_router
//
// Self-checking bench for spi_endpoint_router (nbits=32, addr_nbits=2,
// num_ends=4). Endpoint i always offers response payload 0x10+i.
//
// Each cycle follows the same order:
//   1. Wait for the rising edge, then 1 time unit.
//   2. Drive the inputs.
//   3. Wait 1 time unit for the combinational logic to settle.
//   4. Check the outputs.
// The next rising edge then commits that cycle.
// -----------------------------------------------------------------------------
module tb_spi_endpoint_router;

   logic        clk = 1'b0;
   logic        reset;
   logic        recv_val;
   logic [31:0] recv_msg;
   logic        recv_rdy;
   logic        send_val;
   logic [31:0] send_msg;
   logic        send_rdy;
   logic [3:0]  ep_req_val;
   logic [29:0] ep_req_msg;
   logic [3:0]  ep_req_rdy;
   logic [3:0]  ep_resp_val;
   logic [119:0] ep_resp_msg;
   logic [3:0]  ep_resp_rdy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   spi_endpoint_router #(.nbits(32), .addr_nbits(2), .num_ends(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .recv_val    (recv_val),
      .recv_msg    (recv_msg),
      .recv_rdy    (recv_rdy),
      .send_val    (send_val),
      .send_msg    (send_msg),
      .send_rdy    (send_rdy),
      .ep_req_val  (ep_req_val),
      .ep_req_msg  (ep_req_msg),
      .ep_req_rdy  (ep_req_rdy),
      .ep_resp_val (ep_resp_val),
      .ep_resp_msg (ep_resp_msg),
      .ep_resp_rdy (ep_resp_rdy)
   );

   typedef struct {
      logic        rst;
      logic        rv;
      logic [31:0] rmsg;
      logic [3:0]  qrdy;
      logic [3:0]  pval;
      logic        srdy;
      logic        e_rrdy;
      logic [3:0]  e_qval;
      logic [29:0] e_qmsg;
      logic [3:0]  e_prdy;
      logic        e_sval;
      logic [31:0] e_smsg;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic vec_t v(logic rst, logic rv, logic [31:0] rmsg,
                              logic [3:0] qrdy, logic [3:0] pval, logic srdy,
                              logic e_rrdy, logic [3:0] e_qval,
                              logic [29:0] e_qmsg, logic [3:0] e_prdy,
                              logic e_sval, logic [31:0] e_smsg);
      vec_t r;
      r.rst = rst;       r.rv = rv;         r.rmsg = rmsg;
      r.qrdy = qrdy;     r.pval = pval;     r.srdy = srdy;
      r.e_rrdy = e_rrdy; r.e_qval = e_qval; r.e_qmsg = e_qmsg;
      r.e_prdy = e_prdy; r.e_sval = e_sval; r.e_smsg = e_smsg;
      return r;
   endfunction

   task automatic check(string name, logic [31:0] actual, logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                  name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      ep_resp_msg = {30'h13, 30'h12, 30'h11, 30'h10};
      reset       = 1'b1;
      recv_val    = 1'b1;
      recv_msg    = 32'h8000_00AB;
      ep_req_rdy  = 4'hF;
      ep_resp_val = 4'hF;
      send_rdy    = 1'b1;

      // Columns:
      //   stimulus: rst, recv_val, recv_msg, ep_req_rdy, ep_resp_val, send_rdy
      //   expected: recv_rdy, ep_req_val, ep_req_msg, ep_resp_rdy, send_val, send_msg
      // Reset is held 2 cycles (with the unchecked cycle below), then released.
      vecs[0]  = v(1,1,32'h8000_00AB,4'hF,4'hF,1, 0,4'h0,30'h0, 4'h0,0,32'h0);
      vecs[1]  = v(0,0,32'h0,        4'hF,4'h0,1, 1,4'h0,30'h0, 4'h0,0,32'h0);
      // Routing, back-to-back with no bubble.
      vecs[2]  = v(0,1,32'h8000_00AB,4'hF,4'h0,1, 1,4'h0,30'h0, 4'h0,0,32'h0);
      vecs[3]  = v(0,1,32'h4000_0001,4'hF,4'h0,1, 1,4'h4,30'hAB,4'h0,0,32'h0);
      vecs[4]  = v(0,1,32'hC000_0003,4'hF,4'h0,1, 1,4'h2,30'h1, 4'h0,0,32'h0);
      vecs[5]  = v(0,1,32'h8000_0005,4'hF,4'h0,1, 1,4'h8,30'h3, 4'h0,0,32'h0);
      // Request backpressure on endpoint 2.
      vecs[6]  = v(0,1,32'h0000_0006,4'hB,4'h0,1, 0,4'h4,30'h5, 4'h0,0,32'h0);
      vecs[7]  = v(0,1,32'h0000_0006,4'hB,4'h0,1, 0,4'h4,30'h5, 4'h0,0,32'h0);
      vecs[8]  = v(0,1,32'h0000_0006,4'hB,4'h0,1, 0,4'h4,30'h5, 4'h0,0,32'h0);
      vecs[9]  = v(0,1,32'h0000_0006,4'hF,4'h0,1, 1,4'h4,30'h5, 4'h0,0,32'h0);
      vecs[10] = v(0,0,32'h0,        4'hF,4'h0,1, 1,4'h1,30'h6, 4'h0,0,32'h0);
      vecs[11] = v(0,0,32'h0,        4'hF,4'h0,1, 1,4'h0,30'h0, 4'h0,0,32'h0);
      // Round-robin with all endpoints valid, including the wrap.
      vecs[12] = v(0,0,32'h0,4'hF,4'hF,1, 1,4'h0,30'h0,4'h1,0,32'h0);
      vecs[13] = v(0,0,32'h0,4'hF,4'hF,1, 1,4'h0,30'h0,4'h2,1,32'h0000_0010);
      vecs[14] = v(0,0,32'h0,4'hF,4'hF,1, 1,4'h0,30'h0,4'h4,1,32'h4000_0011);
      vecs[15] = v(0,0,32'h0,4'hF,4'hF,1, 1,4'h0,30'h0,4'h8,1,32'h8000_0012);
      vecs[16] = v(0,0,32'h0,4'hF,4'hF,1, 1,4'h0,30'h0,4'h1,1,32'hC000_0013);
      vecs[17] = v(0,0,32'h0,4'hF,4'h0,1, 1,4'h0,30'h0,4'h0,1,32'h0000_0010);
      // ep1 only (rr_ptr becomes 2), then ep1+ep3 valid: ep3 wins first.
      vecs[18] = v(0,0,32'h0,4'hF,4'h2,1, 1,4'h0,30'h0,4'h2,0,32'h0);
      vecs[19] = v(0,0,32'h0,4'hF,4'hA,1, 1,4'h0,30'h0,4'h8,1,32'h4000_0011);
      vecs[20] = v(0,0,32'h0,4'hF,4'hA,1, 1,4'h0,30'h0,4'h2,1,32'hC000_0013);
      vecs[21] = v(0,0,32'h0,4'hF,4'h0,1, 1,4'h0,30'h0,4'h0,1,32'h4000_0011);
      vecs[22] = v(0,0,32'h0,4'hF,4'h0,1, 1,4'h0,30'h0,4'h0,0,32'h0);

      // Unchecked first reset edge, so the table starts from a known state.
      @(posedge clk);

      for (int n = 0; n < NV; n++) begin
         #1;
         reset       = vecs[n].rst;
         recv_val    = vecs[n].rv;
         recv_msg    = vecs[n].rmsg;
         ep_req_rdy  = vecs[n].qrdy;
         ep_resp_val = vecs[n].pval;
         send_rdy    = vecs[n].srdy;
         settle();
         check($sformatf("v%0d recv_rdy", n),    32'(recv_rdy),    32'(vecs[n].e_rrdy));
         check($sformatf("v%0d ep_req_val", n),  32'(ep_req_val),  32'(vecs[n].e_qval));
         if (vecs[n].e_qval != 4'h0)
            check($sformatf("v%0d ep_req_msg", n), 32'(ep_req_msg), 32'(vecs[n].e_qmsg));
         check($sformatf("v%0d ep_resp_rdy", n), 32'(ep_resp_rdy), 32'(vecs[n].e_prdy));
         check($sformatf("v%0d send_val", n),    32'(send_val),    32'(vecs[n].e_sval));
         if (vecs[n].e_sval)
            check($sformatf("v%0d send_msg", n), send_msg, vecs[n].e_smsg);
         @(posedge clk);
      end

      // Response backpressure, starting from rr_ptr=2 with the buffer empty.
      #1;
      ep_resp_val = 4'hF;
      send_rdy    = 1'b0;
      settle();
      check("bp fill ep_resp_rdy", 32'(ep_resp_rdy), 32'h4);
      for (int c = 0; c < 5; c++) begin
         tick();
         settle();
         check($sformatf("bp%0d send_val", c),    32'(send_val),    32'h1);
         check($sformatf("bp%0d send_msg", c),    send_msg,         32'h8000_0012);
         check($sformatf("bp%0d ep_resp_rdy", c), 32'(ep_resp_rdy), 32'h0);
      end
      // Releasing send_rdy resumes at ep3, which shows rr_ptr held at 3.
      tick();
      send_rdy = 1'b1;
      settle();
      check("bp resume ep_resp_rdy", 32'(ep_resp_rdy), 32'h8);
      check("bp resume send_msg",    send_msg,         32'h8000_0012);
      tick();
      settle();
      check("bp r1 send_msg",    send_msg,         32'hC000_0013);
      check("bp r1 ep_resp_rdy", 32'(ep_resp_rdy), 32'h1);
      tick();
      settle();
      check("bp r2 send_msg",    send_msg,         32'h0000_0010);
      check("bp r2 ep_resp_rdy", 32'(ep_resp_rdy), 32'h2);
      tick();
      ep_resp_val = 4'h0;
      settle();
      check("bp r3 send_msg", send_msg,        32'h4000_0011);
      check("bp r3 send_val", 32'(send_val),   32'h1);
      tick();
      settle();
      check("bp drained send_val", 32'(send_val), 32'h0);

      // Reset mid-flight. rr_ptr is 2 here, so ep0 is the only candidate.
      tick();
      recv_val    = 1'b1;
      recv_msg    = 32'h4000_0077;
      ep_req_rdy  = 4'h0;
      ep_resp_val = 4'h1;
      send_rdy    = 1'b0;
      settle();
      check("mf fill recv_rdy",    32'(recv_rdy),    32'h1);
      check("mf fill ep_resp_rdy", 32'(ep_resp_rdy), 32'h1);
      tick();
      reset       = 1'b1;
      ep_req_rdy  = 4'hF;
      ep_resp_val = 4'hF;
      send_rdy    = 1'b1;
      settle();
      check("mf rst recv_rdy",    32'(recv_rdy),    32'h0);
      check("mf rst ep_resp_rdy", 32'(ep_resp_rdy), 32'h0);
      check("mf full ep_req_val", 32'(ep_req_val),  32'h2);
      check("mf full send_val",   32'(send_val),    32'h1);
      tick();
      reset       = 1'b0;
      recv_val    = 1'b0;
      ep_resp_val = 4'h0;
      settle();
      check("mf post recv_rdy", 32'(recv_rdy), 32'h1);
      for (int c = 0; c < 4; c++) begin
         check($sformatf("mf post%0d send_val", c),   32'(send_val),   32'h0);
         check($sformatf("mf post%0d ep_req_val", c), 32'(ep_req_val), 32'h0);
         tick();
         settle();
      end
      // rr_ptr was 1 before reset. After reset it is 0, so ep0 wins.
      ep_resp_val = 4'hF;
      settle();
      check("mf rr_ptr cleared ep_resp_rdy", 32'(ep_resp_rdy), 32'h1);
      tick();
      ep_resp_val = 4'h0;
      settle();
      check("mf new send_msg", send_msg, 32'h0000_0010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_endpoint_router.md
Name: spi_endpoint_router

Overview:
Sits directly downstream of the SPI stack and consumes the stack's 32-bit request stream, on the stack's send side. Decodes a destination field in the top bits of each request and forwards the remaining payload to one of num_ends endpoints (accelerators, register files). Merges endpoint responses back into a single stream using round-robin arbitration. Each response is tagged with its source id and returned to the stack's recv side.

Parameters:
nbits, 32, width of upstream request/response messages (equals SPI stack message width)
addr_nbits, 2, width of destination/source id field at msg[nbits-1 -: addr_nbits]
num_ends, 4, number of endpoints; always 2**addr_nbits

Ports:
clk  input  1  clock
reset  input  1  reset; synchronous, active-high
recv_val  input  1  upstream request valid
recv_msg  input  nbits  upstream request: {dest, payload}
recv_rdy  output  1  upstream request ready
send_val  output  1  upstream response valid
send_msg  output  nbits  upstream response: {src_id, payload}
send_rdy  input  1  upstream response ready
ep_req_val  output  num_ends  per-endpoint request valid (one-hot or zero)
ep_req_msg  output  nbits-addr_nbits  request payload, broadcast to all endpoints
ep_req_rdy  input  num_ends  per-endpoint request ready
ep_resp_val  input  num_ends  per-endpoint response valid
ep_resp_msg  input  num_ends*(nbits-addr_nbits)  packed responses; endpoint i at [i*P +: P], P=nbits-addr_nbits
ep_resp_rdy  output  num_ends  per-endpoint response ready (one-hot or zero)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous, active-high. All state clears on the first rising edge with reset=1.
- Reset values: req_full=0, resp_full=0, rr_ptr=0. While reset=1, force recv_rdy=0 and ep_resp_rdy=0; send_val=0 and ep_req_val=0 follow from the cleared flags.
- Reset mid-operation: contents of both buffers are discarded and no handshake completes. Upstream and endpoints must re-issue.
- Handshakes: val/rdy throughout; a transfer occurs when val&&rdy at a rising edge. val must not depend combinationally on rdy. All outputs are registered except recv_rdy and ep_resp_rdy.
- Request path, one-entry pipe buffer:
  - req_buf holds {dest, payload}.
  - recv_rdy = !req_full || ep_req_rdy[dest_buf].
  - ep_req_val[i] = req_full && (dest_buf==i).
  - ep_req_msg = payload_buf, i.e. recv_msg[nbits-addr_nbits-1:0].
- Request timing and ordering:
  - Latency 1 cycle: accepted at edge t, presented to the endpoint from t+1.
  - Throughput 1/cycle when the target endpoint is ready; simultaneous drain and refill in the same cycle is allowed.
  - When the target endpoint stalls, all requests stall; there is no reordering and no bypass to other endpoints (head-of-line blocking is intended).
  - Buffer contents stay stable while not drained.
- Response path, round-robin arbiter plus one-entry buffer:
  - arb_en = !resp_full || send_rdy.
  - grant = first i in order rr_ptr, rr_ptr+1, ... (mod num_ends) with ep_resp_val[i]=1.
  - ep_resp_rdy[i] = arb_en && any_val && grant==i.
  - On a grant, resp_buf <= {grant[addr_nbits-1:0], ep_resp_msg[i]} and resp_full <= 1; otherwise resp_full <= resp_full && !send_rdy.
  - send_val = resp_full; send_msg = resp_buf.
- Round-robin pointer:
  - rr_ptr <= (grant+1) mod num_ends, only on a completed grant; it wraps from num_ends-1 to 0.
  - No grant leaves rr_ptr unchanged.
  - Latency 1 cycle. Throughput 1/cycle under send_rdy=1.
- Fairness and ordering:
  - With all endpoints continuously valid, each is granted exactly once per num_ends consecutive grants.
  - Per-endpoint response order is preserved.
- Path independence: the request and response paths are fully independent, and same-cycle activity on both is legal. The router does not track outstanding transactions and does not require one response per request.
- Width rules: P = nbits-addr_nbits. The id field is truncated to addr_nbits, and no arithmetic overflow is possible.

Test Plan:
1. Reset: hold reset 2 cycles with recv_val=1 and all ep_resp_val=1 -> recv_rdy=0, ep_resp_rdy=0000, send_val=0, ep_req_val=0000; the cycle after release recv_rdy=1.
2. Routing: recv_msg=0x8000_00AB, all ep_req_rdy=1 -> next cycle ep_req_val=0100 and ep_req_msg=0x0000_00AB. Then back-to-back 0x4000_0001 and 0xC000_0003 -> ep_req_val=0010 then 1000 on consecutive cycles, with no bubble.
3. Request backpressure: ep_req_rdy[2]=0 while 0x8000_0005 is buffered, next request 0x0000_0006 -> recv_rdy=0, ep_req_val=0100 and ep_req_msg stable. Raise ep_req_rdy[2] -> drains, then ep_req_val=0001 with msg 0x6 the following cycle.
4. Round-robin: all ep_resp_val=1 with payloads 0x10..0x13, send_rdy=1 -> send_msg sequence 0x0000_0010, 0x4000_0011, 0x8000_0012, 0xC000_0013, 0x0000_0010 (wrap). Then with only ep1 and ep3 valid and rr_ptr=2 -> ep3 is granted first.
5. Response backpressure: send_rdy=0 with resp_full=1 -> send_val=1, send_msg stable, ep_resp_rdy=0000 for 5 cycles and rr_ptr unchanged. Raise send_rdy -> one transfer per cycle resumes.
6. Reset mid-flight: both buffers full, assert reset 1 cycle -> send_val=0 and ep_req_val=0000 next cycle; neither buffered message is ever delivered after release.
